// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: elastic pipeline-stage register with a 2-entry skid.
//
// The main entry (M) drives oData/oCtrl. The skid entry (S) catches the word
// accepted in the cycle the downstream stalls. Because oInReady is a register,
// downstream back-pressure never reaches upstream through combinational logic.
// Stall, flush and bubble insertion are supported. oCtrl is forced to zero
// whenever the stage is empty, so an empty stage never asserts side effects.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   defined   -> oStallCnt port plus a saturating stall counter
//   undefined -> no oStallCnt port and no counter logic
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              oInReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [CTRL_W-1:0] InCtrl,
  output logic              oValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] oData,
  output logic [CTRL_W-1:0] oCtrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  oStallCnt
`endif
);

  // Elaboration-time sanity check on the widths.
  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("pipe_stage_skid_reg: DATA_W, CTRL_W and CNT_W must all be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              accept;
  logic              emit;

  // Both outputs are registers, so these handshakes only read flops.
  assign accept = InValid & oInReady;
  assign emit   = oValid & OutReady;

  // Stage FSM. Outputs are registered, with priority Reset > Flush > handshake.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= EMPTY;
      oValid   <= 1'b0;
      oInReady <= 1'b1;
      oData    <= '0;
      oCtrl    <= '0;
      s_data   <= '0;
      s_ctrl   <= '0;
    end else if (Flush) begin
      // Squash everything held. An accept in this cycle is dropped.
      state    <= EMPTY;
      oValid   <= 1'b0;
      oInReady <= 1'b1;
      oData    <= '0;
      oCtrl    <= '0;
      s_data   <= '0;
      s_ctrl   <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            oValid <= 1'b1;
            oData  <= InData;
            oCtrl  <= InCtrl;
          end
        end
        ONE: begin
          if (accept && emit) begin
            // Pass-through: replace M in place, which keeps full throughput.
            oData <= InData;
            oCtrl <= InCtrl;
          end else if (accept) begin
            // Downstream stalled: park the new word in the skid entry.
            state    <= FULL;
            oInReady <= 1'b0;
            s_data   <= InData;
            s_ctrl   <= InCtrl;
          end else if (emit) begin
            // Drained. Insert a bubble: control is zeroed, data is left as is.
            state  <= EMPTY;
            oValid <= 1'b0;
            oCtrl  <= '0;
          end
        end
        FULL: begin
          if (emit) begin
            state    <= ONE;
            oInReady <= 1'b1;
            oData    <= s_data;
            oCtrl    <= s_ctrl;
          end
        end
        default: begin
          state    <= EMPTY;
          oValid   <= 1'b0;
          oInReady <= 1'b1;
          oCtrl    <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Stall counter: counts cycles where output is held and saturates.
  // Only Reset clears it, so a Flush leaves the count in place.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      oStallCnt <= '0;
    end else if (oValid && !OutReady && (oStallCnt != {CNT_W{1'b1}})) begin
      oStallCnt <= oStallCnt + 1'b1;
    end
  end
`endif

endmodule
